// File: rtl/program_image_loader_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// program_image_loader_pkg - shared types and segment bases for the boot loader
// rev 1.0
// ----------------------------------------------------------------------------
package program_image_loader_pkg;

  localparam int unsigned PHYS_ADDR_W = 21;

  localparam logic [PHYS_ADDR_W-1:0] CODE_SEGMENT_START = 21'h00_1000;
  localparam logic [PHYS_ADDR_W-1:0] DATA_SEGMENT_START = 21'h01_0000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CODE_FILL = 3'd1,
    CODE_WR   = 3'd2,
    DATA_FILL = 3'd3,
    DATA_WR   = 3'd4,
    DONE      = 3'd5,
    ERROR     = 3'd6
  } loader_state_t;

  typedef struct packed {
    logic [PHYS_ADDR_W-1:0] addr;
    logic [63:0]            data;
    logic [7:0]             mask;
  } MemWriteReq;

endpackage
`default_nettype wire

// File: rtl/program_image_loader_byte_word_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// byte_word_packer - gathers bytes into a little-endian 64-bit word with lane mask
// rev 1.0
// ----------------------------------------------------------------------------
module byte_word_packer (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic [7:0]  byte_i,
  input  logic        clear_i,
  output logic [3:0]  idx_o,
  output logic [63:0] data_o,
  output logic [7:0]  mask_o
);

  logic [3:0]  idx_q,  idx_d;
  logic [63:0] data_q, data_d;
  logic [7:0]  mask_q, mask_d;

  always_comb begin
    idx_d  = idx_q;
    data_d = data_q;
    mask_d = mask_q;
    if (clear_i) begin
      idx_d  = '0;
      data_d = '0;
      mask_d = '0;
    end else if (load_i) begin
      data_d[{idx_q[2:0], 3'b000} +: 8] = byte_i;
      mask_d[idx_q[2:0]]                = 1'b1;
      idx_d                             = idx_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idx_q  <= '0;
      data_q <= '0;
      mask_q <= '0;
    end else begin
      idx_q  <= idx_d;
      data_q <= data_d;
      mask_q <= mask_d;
    end
  end

  assign idx_o  = idx_q;
  assign data_o = data_q;
  assign mask_o = mask_q;

endmodule
`default_nettype wire

// File: rtl/program_image_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// program_image_loader - streams boot code/data images into DRAM, then releases
// the core. rev 1.0
// ----------------------------------------------------------------------------
module program_image_loader
  import program_image_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = PHYS_ADDR_W,
  parameter logic [ADDR_W-1:0] CODE_BASE = ADDR_W'(CODE_SEGMENT_START),
  parameter logic [ADDR_W-1:0] DATA_BASE = ADDR_W'(DATA_SEGMENT_START),
  parameter int unsigned       SEG_BYTES = 32768
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [7:0]        in_byte_i,
  input  logic              in_last_i,
  input  logic              in_empty_i,
  output logic              mem_wr_valid_o,
  input  logic              mem_wr_ready_i,
  output logic [ADDR_W-1:0] mem_wr_addr_o,
  output logic [63:0]       mem_wr_data_o,
  output logic [7:0]        mem_wr_mask_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic              core_run_o
);

  localparam int unsigned CNT_W = $clog2(SEG_BYTES + 1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              last_q,  last_d;

  logic [3:0] idx;
  logic       fill, wr, beat, empty_last, overflow, load, ack;

  assign fill       = (state_q == CODE_FILL) || (state_q == DATA_FILL);
  assign wr         = (state_q == CODE_WR)   || (state_q == DATA_WR);
  assign beat       = fill && in_valid_i;
  assign empty_last = in_last_i && in_empty_i;
  assign overflow   = beat && !empty_last && (cnt_q == CNT_W'(SEG_BYTES));
  assign load       = beat && !empty_last && !overflow;
  assign ack        = wr && mem_wr_ready_i;

  byte_word_packer u_packer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (load),
    .byte_i  (in_byte_i),
    .clear_i (ack),
    .idx_o   (idx),
    .data_o  (mem_wr_data_o),
    .mask_o  (mem_wr_mask_o)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CODE_FILL;
          addr_d  = CODE_BASE;
          cnt_d   = '0;
          last_d  = 1'b0;
        end
      end
      CODE_FILL, DATA_FILL: begin
        if (overflow) begin
          state_d = ERROR;
        end else if (beat && empty_last && (idx == 4'd0)) begin
          // Nothing buffered: skip the write and move straight on.
          if (state_q == CODE_FILL) begin
            state_d = DATA_FILL;
            addr_d  = DATA_BASE;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
          end
        end else if (beat) begin
          if (load) cnt_d = cnt_q + CNT_W'(1);
          last_d = in_last_i;
          if (in_last_i || (idx == 4'd7)) begin
            if (state_q == CODE_FILL) state_d = CODE_WR;
            else                      state_d = DATA_WR;
          end
        end
      end
      CODE_WR, DATA_WR: begin
        if (mem_wr_ready_i) begin
          addr_d = addr_q + ADDR_W'(8);
          if (!last_q) begin
            if (state_q == CODE_WR) state_d = CODE_FILL;
            else                    state_d = DATA_FILL;
          end else begin
            last_d = 1'b0;
            if (state_q == CODE_WR) begin
              state_d = DATA_FILL;
              addr_d  = DATA_BASE;
              cnt_d   = '0;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign in_ready_o     = fill;
  assign mem_wr_valid_o = wr;
  assign mem_wr_addr_o  = addr_q;
  assign busy_o         = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);
  assign done_o         = (state_q == DONE);
  assign core_run_o     = (state_q == DONE);
  assign error_o        = (state_q == ERROR);

endmodule
`default_nettype wire
